uart_param_ctrl: RTL and testbench
==================================

Name: uart_param_ctrl

Overview:
Link-layer sequencer between the 32-bit UART pair (uart_rx32 / uart_tx32) and the QMC-LSM pricing core. Hunts for a sync word, collects NUM_PARAMS Q16.16 parameter words into a register bank and pulses the core's start. It then waits for the core's done and streams NUM_RESULTS result words back through the transmitter. Inter-word timeout and framing errors return the block to sync hunt.

Parameters:
NUM_PARAMS, 7, parameter words per frame (S0, K, steps, paths, r, sigma, T ordering fixed by host)
NUM_RESULTS, 2, result words returned per run
SYNC_WORD, 32'hA5A5_0007, frame header word
RX_TIMEOUT_CYC, 1_000_000, max clk cycles between consecutive rx words inside a frame

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_valid  in  1  one-cycle pulse from uart_rx32, word available
rx_data  in  32  received word
tx_valid  out  1  word offered to uart_tx32
tx_data  out  32  word to transmit
tx_ready  in  1  uart_tx32 can accept; transfer = tx_valid & tx_ready
params  out  NUM_PARAMS*32  parameter bank, word i at [32*i+31:32*i]
core_start  out  1  one-cycle start pulse to core
core_done  in  1  one-cycle pulse, core_result valid this cycle
core_result  in  NUM_RESULTS*32  result vector
busy  out  1  high in every state except IDLE
timeout_err  out  1  one-cycle pulse on rx timeout
frame_err  out  1  one-cycle pulse on rx word arriving during RUN/SEND

Behaviour:
- Reset (async assert, sync release): state=IDLE; params, tx_data, result latch, word index, timeout counter = 0; tx_valid, core_start, timeout_err, frame_err, busy = 0.
- IDLE: rx_valid with rx_data==SYNC_WORD -> RECV, idx=0, timer=0. Other words ignored silently.
- RECV: timer increments each cycle, clears on rx_valid. rx_valid -> params[idx]<=rx_data; idx==NUM_PARAMS-1 -> START, else idx++. A SYNC_WORD value inside RECV is stored as data (no resync). timer reaches RX_TIMEOUT_CYC-1 without rx_valid -> timeout_err pulse, IDLE. params keeps partially written words (not cleared).
- START: core_start=1 for exactly one cycle -> RUN. params stable from START until next frame's first write.
- RUN: wait core_done; on core_done latch core_result, idx=0 -> SEND. No timeout in RUN.
- SEND: tx_valid=1, tx_data=result[idx]. Hold both stable until tx_ready sampled high. On transfer: idx==NUM_RESULTS-1 -> IDLE (tx_valid=0 next cycle), else idx++ and next word presented the following cycle (back-to-back allowed if tx_ready stays high).
- rx_valid in RUN or SEND: word dropped, frame_err pulse, state unaffected.
- core_done outside RUN: ignored.
- Latency: last param rx_valid (cycle n) -> core_start high at n+1. core_done (cycle m) -> tx_valid high at m+1.
- Reset mid-frame or mid-send: immediate return to reset values; the word in flight in uart_tx32 is not the controller's concern.
- All data passed unmodified (no Q16.16 arithmetic here). Counters sized $clog2 of their bound, min 1 bit.

Decomposition:
- Package uart_ctrl_pkg: state enum (IDLE, RECV, START, RUN, SEND), SYNC_WORD default, word-width localparam (32).
- No sub-module required. Timeout counter is inline; optional sub-module rx_timeout_timer (load/clear/expire) if reused by future host link blocks.

Test Plan:
- Nominal: send A5A50007 then 00002710, 00000032, 00640000, 00640000, 0000CCC0, 00033333, 00010000 -> params match in order, core_start single pulse 1 cycle after last word; model returns core_done with {0001_8000, 0000_4000} -> tx emits 00004000 then 00018000 (result[0] first), busy falls after the second transfer.
- Pre-sync junk: words 12345678, DEADBEEF, then a valid frame -> junk ignored, no errors, nominal result.
- Timeout: sync + 3 words, then silence RX_TIMEOUT_CYC cycles (bench overrides parameter to 1000) -> timeout_err pulse, state IDLE, no core_start; a following full frame completes normally.
- TX backpressure: hold tx_ready low 50 cycles during SEND -> tx_valid/tx_data stable throughout; exactly NUM_RESULTS transfers.
- Stray rx in RUN: inject rx_valid during RUN -> frame_err pulse, params unchanged, run completes.
- Reset mid-RECV after 4 words -> all outputs at reset values; next frame processed correctly.
- Full UART loopback (uart_tx32 -> uart_rx32 -> ctrl) at 115200 baud -> same result as the nominal case.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART parameter/result link controller.
package uart_ctrl_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] SYNC_WORD_DEFAULT = 32'hA5A5_0007;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        START = 3'd2,
        RUN   = 3'd3,
        SEND  = 3'd4
    } ctrl_state_e;

    // Bits needed for a counter that must reach bound-1, never less than one bit.
    function automatic int cnt_width(input int bound);
        return (bound > 1) ? $clog2(bound) : 1;
    endfunction

endpackage

// File: rtl/uart_param_ctrl.sv
// Link-layer sequencer: hunts for the sync word, fills the parameter bank,
// kicks the pricing core, then streams its result words out through the UART.
//
// Handshakes: rx_valid is a one-cycle pulse with no back-pressure; core_start
// and core_done are one-cycle pulses; on the TX side a word moves only on a
// cycle where tx_valid & tx_ready, and tx_valid/tx_data hold steady until then.
module uart_param_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int                 NUM_PARAMS     = 7,
    parameter int                 NUM_RESULTS    = 2,
    parameter logic [WORD_W-1:0]  SYNC_WORD      = SYNC_WORD_DEFAULT,
    parameter int                 RX_TIMEOUT_CYC = 1_000_000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_valid,
    input  logic [WORD_W-1:0]             rx_data,
    output logic                          tx_valid,
    output logic [WORD_W-1:0]             tx_data,
    input  logic                          tx_ready,
    output logic [NUM_PARAMS*WORD_W-1:0]  params,
    output logic                          core_start,
    input  logic                          core_done,
    input  logic [NUM_RESULTS*WORD_W-1:0] core_result,
    output logic                          busy,
    output logic                          timeout_err,
    output logic                          frame_err,
    output ctrl_state_e                   dbg_state
);

    localparam int IDX_BOUND = (NUM_PARAMS > NUM_RESULTS) ? NUM_PARAMS : NUM_RESULTS;
    localparam int IDX_W     = cnt_width(IDX_BOUND);
    localparam int TMR_W     = cnt_width(RX_TIMEOUT_CYC);

    localparam logic [IDX_W-1:0] LAST_PARAM  = IDX_W'(NUM_PARAMS - 1);
    localparam logic [IDX_W-1:0] LAST_RESULT = IDX_W'(NUM_RESULTS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(RX_TIMEOUT_CYC - 1);

    ctrl_state_e                   state_q,  state_d;
    logic [IDX_W-1:0]              idx_q,    idx_d;
    logic [TMR_W-1:0]              timer_q,  timer_d;
    logic [NUM_PARAMS*WORD_W-1:0]  params_q, params_d;
    logic [NUM_RESULTS*WORD_W-1:0] result_q, result_d;
    logic                          terr_q,   terr_d;
    logic                          ferr_q,   ferr_d;
    logic [WORD_W-1:0]             tx_word;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            timer_q  <= '0;
            params_q <= '0;
            result_q <= '0;
            terr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            timer_q  <= timer_d;
            params_q <= params_d;
            result_q <= result_d;
            terr_q   <= terr_d;
            ferr_q   <= ferr_d;
        end
    end

    // Next-state logic: frame collection, core handoff and result streaming.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        timer_d  = timer_q;
        params_d = params_q;
        result_d = result_q;
        terr_d   = 1'b0;
        ferr_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rx_valid && (rx_data == SYNC_WORD)) begin
                    state_d = RECV;
                    idx_d   = '0;
                    timer_d = '0;
                end
            end
            RECV: begin
                // A sync-valued word here is payload, not a resync request.
                if (rx_valid) begin
                    timer_d = '0;
                    for (int i = 0; i < NUM_PARAMS; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            params_d[WORD_W*i +: WORD_W] = rx_data;
                        end
                    end
                    if (idx_q == LAST_PARAM) begin
                        state_d = START;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (timer_q == TMR_LAST) begin
                    // Partially written params are deliberately left in place.
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            START: begin
                state_d = RUN;
            end
            RUN: begin
                ferr_d = rx_valid;
                if (core_done) begin
                    result_d = core_result;
                    idx_d    = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                ferr_d = rx_valid;
                if (tx_ready) begin
                    if (idx_q == LAST_RESULT) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Result word selected for transmission; zero whenever nothing is offered.
    always_comb begin
        tx_word = '0;
        for (int i = 0; i < NUM_RESULTS; i++) begin
            if ((state_q == SEND) && (idx_q == IDX_W'(i))) begin
                tx_word = result_q[WORD_W*i +: WORD_W];
            end
        end
    end

    assign tx_valid    = (state_q == SEND);
    assign tx_data     = tx_word;
    assign core_start  = (state_q == START);
    assign busy        = (state_q != IDLE);
    assign params      = params_q;
    assign timeout_err = terr_q;
    assign frame_err   = ferr_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_param_ctrl.sv
// Directed bench for uart_param_ctrl with a frame-level reference model.
module tb_uart_param_ctrl;
    import uart_ctrl_pkg::*;

    localparam int NP = 7;
    localparam int NR = 2;
    localparam int TO = 1000;
    localparam logic [31:0] SYNC = 32'hA5A5_0007;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              rx_valid = 1'b0;
    logic [31:0]       rx_data  = '0;
    logic              tx_valid;
    logic [31:0]       tx_data;
    logic              tx_ready = 1'b1;
    logic [NP*32-1:0]  params;
    logic              core_start;
    logic              core_done;
    logic              core_done_auto  = 1'b0;
    logic              core_done_stray = 1'b0;
    logic [NR*32-1:0]  core_result = {32'h0001_8000, 32'h0000_4000};
    logic              busy;
    logic              timeout_err;
    logic              frame_err;
    ctrl_state_e       dbg_state;

    assign core_done = core_done_auto | core_done_stray;

    uart_param_ctrl #(
        .NUM_PARAMS(NP), .NUM_RESULTS(NR), .SYNC_WORD(SYNC), .RX_TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .params(params),
        .core_start(core_start), .core_done(core_done), .core_result(core_result),
        .busy(busy), .timeout_err(timeout_err), .frame_err(frame_err),
        .dbg_state(dbg_state)
    );

    // ---------------- stimulus data ----------------
    logic [31:0] nom [NP] = '{32'h0000_2710, 32'h0000_0032, 32'h0064_0000, 32'h0064_0000,
                              32'h0000_CCC0, 32'h0003_3333, 32'h0001_0000};
    logic [31:0] alt [NP] = '{32'h1111_0001, 32'h0000_0400, 32'hA5A5_0007, 32'h0002_0000,
                              32'h0000_0A3D, 32'h0000_4CCC, 32'h0000_8000};

    // ---------------- counters ----------------
    int n_vec = 0;
    int n_bad = 0;
    int start_cnt = 0;
    int terr_cnt = 0;
    int ferr_cnt = 0;
    int core_lat = 4;
    logic [31:0] got_tx[$];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    // The model tracks what phase of a frame the link is in, which words it
    // owes the host (exp_q), and what the parameter bank must hold.
    logic [31:0] m_params [NP] = '{default: 32'h0};
    logic [31:0] exp_q[$];
    bit m_collect = 0, m_start = 0, m_run = 0, m_terr = 0, m_ferr = 0;
    int m_n = 0, m_silent = 0;

    function automatic void m_clear();
        for (int i = 0; i < NP; i++) m_params[i] = '0;
        exp_q.delete();
        m_collect = 0; m_start = 0; m_run = 0; m_terr = 0; m_ferr = 0;
        m_n = 0; m_silent = 0;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_clear();
        end else begin
            m_terr = 0;
            m_ferr = 0;
            if (m_start) begin
                m_start = 0;
                m_run   = 1;
            end else if (m_run) begin
                m_ferr = rx_valid;
                if (core_done) begin
                    for (int i = 0; i < NR; i++) exp_q.push_back(core_result[32*i +: 32]);
                    m_run = 0;
                end
            end else if (exp_q.size() > 0) begin
                m_ferr = rx_valid;
                if (tx_ready) void'(exp_q.pop_front());
            end else if (m_collect) begin
                if (rx_valid) begin
                    m_params[m_n] = rx_data;
                    m_n++;
                    m_silent = 0;
                    if (m_n == NP) begin
                        m_collect = 0;
                        m_start   = 1;
                    end
                end else begin
                    m_silent++;
                    if (m_silent == TO) begin
                        m_collect = 0;
                        m_terr    = 1;
                    end
                end
            end else if (rx_valid && rx_data == SYNC) begin
                m_collect = 1;
                m_n = 0;
                m_silent = 0;
            end
        end
    end

    // ---------------- scoreboard compare, every cycle ----------------
    initial forever begin
        @(negedge clk);
        chk1("busy", busy, m_collect || m_start || m_run || (exp_q.size() > 0));
        chk1("core_start", core_start, m_start);
        chk1("tx_valid", tx_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) chk32("tx_data", tx_data, exp_q[0]);
        chk1("timeout_err", timeout_err, m_terr);
        chk1("frame_err", frame_err, m_ferr);
        for (int i = 0; i < NP; i++) chk32($sformatf("params[%0d]", i), params[32*i +: 32], m_params[i]);
        if (core_start)  start_cnt++;
        if (timeout_err) terr_cnt++;
        if (frame_err)   ferr_cnt++;
    end

    // Transfer monitor.
    initial forever begin
        @(posedge clk);
        if (rst_n && tx_valid && tx_ready) got_tx.push_back(tx_data);
    end

    // Core stand-in: answers each start after core_lat cycles.
    initial forever begin
        @(posedge clk);
        if (rst_n && core_start) begin
            repeat (core_lat) @(posedge clk);
            #1 core_done_auto = 1'b1;
            @(posedge clk);
            #1 core_done_auto = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_word(input logic [31:0] w);
        rx_data  = w;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input bit use_alt, input int nwords);
        send_word(SYNC);
        for (int i = 0; i < nwords; i++) send_word(use_alt ? alt[i] : nom[i]);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while (busy && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_vec++;
        if (busy) begin
            n_bad++;
            $display("FAIL %s: busy still 1 after %0d cycles, required 0", name, budget);
        end
    endtask

    task automatic chk_tx(input int base, input logic [31:0] w0, input logic [31:0] w1, input string name);
        chk32({name, "_count"}, 32'(got_tx.size() - base), 32'd2);
        if (got_tx.size() >= base + 2) begin
            chk32({name, "_word0"}, got_tx[base], w0);
            chk32({name, "_word1"}, got_tx[base + 1], w1);
        end
    endtask

    // ---------------- test sequence ----------------
    int base, s0, t0, f0, k;

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_tx_valid", tx_valid, 1'b0);
        chk1("rst_core_start", core_start, 1'b0);
        chk1("rst_params_zero", params == '0, 1'b1);
        chk1("rst_state_idle", dbg_state == IDLE, 1'b1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Nominal frame.
        base = got_tx.size();
        s0 = start_cnt;
        send_frame(0, NP);
        chk1("nom_start_latency", core_start, 1'b1);
        @(posedge clk);
        #1;
        chk1("nom_start_one_cycle", core_start, 1'b0);
        wait_idle(200, "nom_idle");
        chk32("nom_param0", params[31:0], 32'h0000_2710);
        chk32("nom_param4", params[32*4 +: 32], 32'h0000_CCC0);
        chk32("nom_param6", params[32*6 +: 32], 32'h0001_0000);
        chk32("nom_start_pulses", 32'(start_cnt - s0), 32'd1);
        chk_tx(base, 32'h0000_4000, 32'h0001_8000, "nom_tx");

        // Junk before sync.
        base = got_tx.size();
        t0 = terr_cnt;
        f0 = ferr_cnt;
        send_word(32'h1234_5678);
        send_word(32'hDEAD_BEEF);
        chk1("junk_ignored", busy, 1'b0);
        send_frame(0, NP);
        wait_idle(200, "junk_idle");
        chk32("junk_no_errs", 32'(terr_cnt - t0 + ferr_cnt - f0), 32'd0);
        chk_tx(base, 32'h0000_4000, 32'h0001_8000, "junk_tx");

        // Inter-word timeout after three alt words.
        s0 = start_cnt;
        t0 = terr_cnt;
        send_frame(1, 3);
        repeat (TO + 5) begin
            @(posedge clk);
            #1;
        end
        chk32("to_pulses", 32'(terr_cnt - t0), 32'd1);
        chk32("to_no_start", 32'(start_cnt - s0), 32'd0);
        chk1("to_idle", busy, 1'b0);
        chk32("to_partial_new", params[32*2 +: 32], 32'hA5A5_0007);
        chk32("to_partial_old", params[32*3 +: 32], 32'h0064_0000);
        base = got_tx.size();
        send_frame(0, NP);
        wait_idle(200, "to_recover_idle");
        chk_tx(base, 32'h0000_4000, 32'h0001_8000, "to_recover_tx");

        // TX back-pressure for 50 cycles.
        base = got_tx.size();
        tx_ready = 1'b0;
        send_frame(0, NP);
        k = 0;
        while (!tx_valid && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk1("bp_valid_seen", tx_valid, 1'b1);
        repeat (50) begin
            @(posedge clk);
            #1;
            chk1("bp_valid_hold", tx_valid, 1'b1);
            chk32("bp_data_hold", tx_data, 32'h0000_4000);
        end
        tx_ready = 1'b1;
        wait_idle(200, "bp_idle");
        chk_tx(base, 32'h0000_4000, 32'h0001_8000, "bp_tx");

        // Stray rx word while the core runs.
        core_lat = 10;
        base = got_tx.size();
        f0 = ferr_cnt;
        send_frame(0, NP);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        send_word(32'hBAD0_BAD0);
        wait_idle(200, "stray_idle");
        chk32("stray_ferr", 32'(ferr_cnt - f0), 32'd1);
        chk32("stray_params", params[31:0], 32'h0000_2710);
        chk_tx(base, 32'h0000_4000, 32'h0001_8000, "stray_tx");
        core_lat = 4;

        // core_done while idle is ignored.
        core_done_stray = 1'b1;
        @(posedge clk);
        #1;
        core_done_stray = 1'b0;
        @(posedge clk);
        #1;
        chk1("idle_done_busy", busy, 1'b0);
        chk1("idle_done_tx", tx_valid, 1'b0);

        // Reset part-way through a frame, then a fresh alt frame.
        send_frame(1, 4);
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_params_zero", params == '0, 1'b1);
        chk1("mid_rst_state", dbg_state == IDLE, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        core_result = {32'hCAFE_0001, 32'h1234_5678};
        base = got_tx.size();
        send_frame(1, NP);
        wait_idle(200, "alt_idle");
        chk32("alt_param2_sync_as_data", params[32*2 +: 32], 32'hA5A5_0007);
        chk32("alt_param6", params[32*6 +: 32], 32'h0000_8000);
        chk_tx(base, 32'h1234_5678, 32'hCAFE_0001, "alt_tx");

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Overall time bound.
    initial begin
        #2_000_000;
        n_bad++;
        $display("FAIL watchdog: sequence incomplete at %0t", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
